fifo_fwft_stream: RTL and testbench
===================================

FIFO_FWFT_STREAM -- requirements
Module: fifo_fwft_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16, payload width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, storage address width; RAM_DEPTH = 2**ADDR_WIDTH; legal range 2..12.
REQ-003 Parameter AF_THRESH, default RAM_DEPTH-2, almost_full asserted when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserted when count <= AE_THRESH.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous clear of contents; sticky error flags unaffected.
REQ-008 in_valid  input  1  producer offers in_data this cycle.
REQ-009 in_data  input  DATA_WIDTH  write payload.
REQ-010 in_ready  output  1  FIFO can accept a write this cycle.
REQ-011 out_valid  output  1  out_data holds the oldest entry (first-word fall-through).
REQ-012 out_data  output  DATA_WIDTH  oldest entry; stable while out_valid=1 and out_ready=0.
REQ-013 out_ready  input  1  consumer takes out_data this cycle.
REQ-014 count  output  ADDR_WIDTH+1  entries accepted and not yet popped, 0..RAM_DEPTH.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags from count.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 A write is accepted when in_valid=1 and in_ready=1; in_ready = (count < RAM_DEPTH), combinational from registered count.
REQ-018 A pop is accepted when out_valid=1 and out_ready=1.
REQ-019 count increments on accepted write only, decrements on accepted pop only, unchanged when both or neither occur.
REQ-020 Fall-through latency: write accepted at edge k into an empty FIFO produces out_valid=1 with that data after edge k+2.
REQ-021 Internal prefetch: RAM read issued when RAM non-empty and (output stage empty or accepted pop); output stage loads the RAM read result one cycle later; back-to-back pops sustain one word per cycle.
REQ-022 count includes words in flight between RAM and output stage; out_valid may lag count by up to 2 cycles after a write into an empty FIFO.
REQ-023 Data order strictly FIFO; read/write pointers wrap modulo RAM_DEPTH.
REQ-024 Write with in_valid=1 and in_ready=0 sets overflow=1; data discarded; no state change.
REQ-025 out_ready=1 with out_valid=0 sets underflow=1; no state change.
REQ-026 Full with simultaneous pop: in_ready stays 0 that cycle (registered count); write not accepted.
REQ-027 flush=1: next edge clears pointers, count, output stage, in-flight read; same-cycle write and pop are ignored; flush has priority over push/pop.
REQ-028 almost_full and almost_empty are combinational from registered count.

Reset
REQ-029 On reset=1 at an edge: count=0, out_valid=0, overflow=0, underflow=0, pointers=0, in-flight read cleared; reset overrides flush, push, pop.
REQ-030 After reset: in_ready=1, almost_empty=1, almost_full=0 (AF_THRESH>0); out_data value don't-care while out_valid=0.

Structure
REQ-031 Shared package holds a localparam helper for count width (ADDR_WIDTH+1) and the legal-range checks for ADDR_WIDTH, AF_THRESH (1..RAM_DEPTH), AE_THRESH (0..RAM_DEPTH-1).
REQ-032 One sub-module: ram_sdp (simple dual-port, 1-cycle synchronous read, no reset on array); control, count and output stage live in fifo_fwft_stream.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=2)
REQ-033 Push 0xA5 at cycle 0, out_ready=0 -> count=1 after edge 0, out_valid=1 and out_data=0xA5 after edge 2; pop -> out_valid=0, count=0 next cycle.
REQ-034 Push 0x00..0x07 then 0x08 -> almost_full after 6th, in_ready=0 after 8th, 0x08 sets overflow=1; drain returns 0x00..0x07 in order, 0x08 never appears.
REQ-035 Continuous writes with out_ready=1 -> after 2-cycle prime one word out per cycle, count constant, no gaps across pointer wrap.
REQ-036 out_ready=1 on empty FIFO -> underflow=1, stays 1 until reset; count remains 0.
REQ-037 5 entries held, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, overflow/underflow unchanged; later push 0x3C appears after 2 edges.
REQ-038 Reset asserted with 4 entries and pending read -> all outputs at reset values next cycle; no stale word emerges afterward.

Source files
------------

// File: rtl/fifo_fwft_stream_pkg.sv
// Shared sizing helpers and parameter range checks for the FWFT stream FIFO.
package fifo_fwft_stream_pkg;

    localparam int MIN_ADDR_WIDTH = 2;
    localparam int MAX_ADDR_WIDTH = 12;

    // count must represent 0..RAM_DEPTH inclusive, hence one extra bit
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit addr_width_ok(input int addr_width);
        return (addr_width >= MIN_ADDR_WIDTH) && (addr_width <= MAX_ADDR_WIDTH);
    endfunction

    function automatic bit af_thresh_ok(input int addr_width, input int af_thresh);
        return (af_thresh >= 1) && (af_thresh <= (1 << addr_width));
    endfunction

    function automatic bit ae_thresh_ok(input int addr_width, input int ae_thresh);
        return (ae_thresh >= 0) && (ae_thresh <= (1 << addr_width) - 1);
    endfunction

endpackage

// File: rtl/fifo_fwft_stream_if.sv
// Producer/consumer handshake, flush and status bundle for the FWFT stream FIFO.
interface fifo_fwft_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    import fifo_fwft_stream_pkg::*;

    localparam int CW = count_width(ADDR_WIDTH);

    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [CW-1:0]         count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_fwft_stream_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port with a registered 1-cycle read.
module fifo_fwft_stream_ram_sdp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // read register holds its word until the next read, acting as a prefetch slot
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_fwft_stream.sv
// First-word-fall-through FIFO: RAM storage, a prefetch slot in the RAM read
// register, and an output stage that always presents the oldest entry.
module fifo_fwft_stream
    import fifo_fwft_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_fwft_stream_if.slave    bus
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int CW        = count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_addr_width
        $error("fifo_fwft_stream: ADDR_WIDTH out of range 2..12");
    end
    if (!af_thresh_ok(ADDR_WIDTH, AF_THRESH)) begin : g_bad_af_thresh
        $error("fifo_fwft_stream: AF_THRESH out of range 1..RAM_DEPTH");
    end
    if (!ae_thresh_ok(ADDR_WIDTH, AE_THRESH)) begin : g_bad_ae_thresh
        $error("fifo_fwft_stream: AE_THRESH out of range 0..RAM_DEPTH-1");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_rd_pending;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_ram_count;
    logic                  w_load;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_in_ready = (r_count < DEPTH_C);
    assign w_push     = bus.in_valid && w_in_ready && !bus.flush;
    assign w_pop      = r_out_valid && bus.out_ready && !bus.flush;

    // count covers RAM, prefetch slot and output stage; what remains is unread RAM
    assign w_ram_count = r_count - CW'(r_rd_pending) - CW'(r_out_valid);

    assign w_load  = r_rd_pending && (!r_out_valid || w_pop) && !bus.flush;
    assign w_rd_en = (w_ram_count != '0) && (!r_rd_pending || w_load) && !bus.flush;

    fifo_fwft_stream_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram_sdp (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.in_data),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_pending <= 1'b0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_pending <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            if (bus.in_valid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
            if (bus.out_ready && !r_out_valid) begin
                r_underflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_rd_en) begin
                r_rd_pending <= 1'b1;
            end else if (w_load) begin
                r_rd_pending <= 1'b0;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // payload needs no reset; it is qualified by out_valid
    always_ff @(posedge clk) begin
        if (w_load && !reset) begin
            r_out_data <= w_rd_data;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.count        = r_count;
    assign bus.almost_full  = (r_count >= AF_C);
    assign bus.almost_empty = (r_count <= AE_C);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_fwft_stream.sv
// Bench for fifo_fwft_stream: queue model with timestamped entries checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fifo_fwft_stream;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic reset;

    fifo_fwft_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_fwft_stream #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: words in acceptance order with the edge number at which each was taken
    int m_data[$];
    int m_time[$];
    int edge_n = 0;
    bit m_ovf  = 1'b0;
    bit m_unf  = 1'b0;
    bit m_live = 1'b0;

    // the oldest word is presented once two edges have passed since it was accepted
    function automatic bit m_valid();
        return (m_data.size() > 0) && (m_time[0] + 2 <= edge_n);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        forever begin : m_step
            bit v;
            bit rdy;
            int e;
            @(posedge clk);
            e   = edge_n + 1;
            v   = m_valid();
            rdy = (m_data.size() < DEPTH);
            if (reset) begin
                m_data.delete();
                m_time.delete();
                m_ovf  = 1'b0;
                m_unf  = 1'b0;
                m_live = 1'b1;
            end else if (bus.flush) begin
                m_data.delete();
                m_time.delete();
            end else begin
                if (bus.in_valid && !rdy) m_ovf = 1'b1;
                if (bus.out_ready && !v)  m_unf = 1'b1;
                if (v && bus.out_ready) begin
                    void'(m_data.pop_front());
                    void'(m_time.pop_front());
                end
                if (bus.in_valid && rdy) begin
                    m_data.push_back(int'(bus.in_data));
                    m_time.push_back(e);
                end
            end
            edge_n = e;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("count",        int'(bus.count),        m_data.size());
            chk("in_ready",     int'(bus.in_ready),     int'(m_data.size() < DEPTH));
            chk("almost_full",  int'(bus.almost_full),  int'(m_data.size() >= AF));
            chk("almost_empty", int'(bus.almost_empty), int'(m_data.size() <= AE));
            chk("overflow",     int'(bus.overflow),     int'(m_ovf));
            chk("underflow",    int'(bus.underflow),    int'(m_unf));
            chk("out_valid",    int'(bus.out_valid),    int'(m_valid()));
            if (m_valid()) begin
                chk("out_data", int'(bus.out_data), m_data[0]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
    endtask

    initial begin : stim
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_count",     int'(bus.count),        0);
        chk("rst_in_ready",  int'(bus.in_ready),     1);
        chk("rst_ae",        int'(bus.almost_empty), 1);
        chk("rst_af",        int'(bus.almost_full),  0);
        chk("rst_out_valid", int'(bus.out_valid),    0);
        chk("rst_ovf",       int'(bus.overflow),     0);
        chk("rst_unf",       int'(bus.underflow),    0);

        // single word fall-through latency
        push(8'hA5);
        step();
        bus.in_valid = 1'b0;
        chk("a_count_e0", int'(bus.count),     1);
        chk("a_valid_e0", int'(bus.out_valid), 0);
        step();
        chk("a_valid_e1", int'(bus.out_valid), 0);
        step();
        chk("a_valid_e2", int'(bus.out_valid), 1);
        chk("a_data_e2",  int'(bus.out_data),  8'hA5);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("a_valid_pop", int'(bus.out_valid), 0);
        chk("a_count_pop", int'(bus.count),     0);

        // fill to full, overflow, ordered drain
        for (int i = 0; i < 8; i++) begin
            push(i);
            step();
            if (i == 1) chk("b_ae_at2", int'(bus.almost_empty), 1);
            if (i == 2) chk("b_ae_at3", int'(bus.almost_empty), 0);
            if (i == 4) chk("b_af_at5", int'(bus.almost_full),  0);
            if (i == 5) chk("b_af_at6", int'(bus.almost_full),  1);
            if (i == 6) chk("b_rdy_at7", int'(bus.in_ready),    1);
        end
        chk("b_rdy_full",   int'(bus.in_ready), 0);
        chk("b_count_full", int'(bus.count),    8);
        push(8'h08);
        step();
        bus.in_valid = 1'b0;
        chk("b_ovf",        int'(bus.overflow), 1);
        chk("b_count_ovf",  int'(bus.count),    8);
        for (int j = 0; j < 8; j++) begin
            chk("b_drain_valid", int'(bus.out_valid), 1);
            chk("b_drain_data",  int'(bus.out_data),  j);
            bus.out_ready = 1'b1;
            step();
        end
        bus.out_ready = 1'b0;
        chk("b_count_empty", int'(bus.count),     0);
        chk("b_valid_empty", int'(bus.out_valid), 0);
        chk("b_unf_clean",   int'(bus.underflow), 0);

        // pop request on empty FIFO
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("d_unf",   int'(bus.underflow), 1);
        chk("d_count", int'(bus.count),     0);
        step();
        step();
        chk("d_unf_sticky", int'(bus.underflow), 1);

        // streaming through pointer wrap
        for (int i = 0; i < 20; i++) begin
            if (i >= 3) begin
                chk("c_valid", int'(bus.out_valid), 1);
                chk("c_data",  int'(bus.out_data),  8'h40 + i - 3);
                chk("c_count", int'(bus.count),     3);
            end
            push(8'h40 + i);
            bus.out_ready = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        bus.out_ready = 1'b0;
        chk("c_count_end", int'(bus.count),     0);
        chk("c_valid_end", int'(bus.out_valid), 0);

        // flush with a concurrent write and pop
        for (int i = 0; i < 5; i++) begin
            push(8'h10 + i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        chk("e_count_pre", int'(bus.count),     5);
        chk("e_valid_pre", int'(bus.out_valid), 1);
        bus.flush     = 1'b1;
        push(8'hEE);
        bus.out_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("e_count", int'(bus.count),     0);
        chk("e_valid", int'(bus.out_valid), 0);
        chk("e_ovf",   int'(bus.overflow),  1);
        chk("e_unf",   int'(bus.underflow), 1);
        push(8'h3C);
        step();
        bus.in_valid = 1'b0;
        chk("e_valid_e0", int'(bus.out_valid), 0);
        chk("e_count_e0", int'(bus.count),     1);
        step();
        chk("e_valid_e1", int'(bus.out_valid), 0);
        step();
        chk("e_valid_e2", int'(bus.out_valid), 1);
        chk("e_data_e2",  int'(bus.out_data),  8'h3C);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("e_count_end", int'(bus.count), 0);

        // reset while entries and a prefetch are in flight
        for (int i = 0; i < 4; i++) begin
            push(8'h21 + i);
            step();
        end
        reset         = 1'b1;
        push(8'h99);
        bus.out_ready = 1'b1;
        step();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("f_count",    int'(bus.count),        0);
        chk("f_valid",    int'(bus.out_valid),    0);
        chk("f_ovf",      int'(bus.overflow),     0);
        chk("f_unf",      int'(bus.underflow),    0);
        chk("f_in_ready", int'(bus.in_ready),     1);
        chk("f_ae",       int'(bus.almost_empty), 1);
        chk("f_af",       int'(bus.almost_full),  0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("f_no_stale", int'(bus.out_valid), 0);
        end
        chk("f_count_end", int'(bus.count), 0);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
